shifter_pipe: RTL and testbench

Parametrised, two-stage pipelined barrel shifter with valid/ready handshaking, five shift modes and result flags. It replaces the single-cycle 16-bit combinational shifter in the ALU path wherever operand width grows or timing needs a register split. It sits between the execute-stage operand mux and the writeback/flag logic, and accepts one operation per cycle under backpressure.

---
 rtl/shifter_pkg.sv | 15 +
 rtl/shifter_pipe_if.sv | 42 ++++
 rtl/shift_stage.sv | 54 +++++
 rtl/shifter_pipe.sv | 120 ++++++++++++
 tb/tb_shifter_pipe.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared types and constants for the two-stage pipelined barrel shifter.
package shifter_pkg;

  localparam int unsigned MODE_W = 3;

  // Encodings 101-111 are pass-through and deliberately have no enumerator.
  typedef enum logic [MODE_W-1:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SRA = 3'b001,
    SHIFT_ROR = 3'b010,
    SHIFT_SRL = 3'b011,
    SHIFT_ROL = 3'b100
  } shift_mode_t;

endpackage

// File: rtl/shifter_pipe_if.sv
// Operand/result handshake bundle for shifter_pipe.
// Shift_cout exists only when SHIFT_COUT_EN is defined.
interface shifter_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic                            flush;
  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                Shift_in;
  logic [SHW-1:0]                  Shift_val;
  logic [shifter_pkg::MODE_W-1:0]  Mode;
  logic                            out_valid;
  logic                            out_ready;
  logic [WIDTH-1:0]                Shift_out;
  logic                            Shift_zero;
`ifdef SHIFT_COUT_EN
  logic                            Shift_cout;

  modport master (
    output flush, in_valid, Shift_in, Shift_val, Mode, out_ready,
    input  in_ready, out_valid, Shift_out, Shift_zero, Shift_cout
  );

  modport slave (
    input  flush, in_valid, Shift_in, Shift_val, Mode, out_ready,
    output in_ready, out_valid, Shift_out, Shift_zero, Shift_cout
  );
`else
  modport master (
    output flush, in_valid, Shift_in, Shift_val, Mode, out_ready,
    input  in_ready, out_valid, Shift_out, Shift_zero
  );

  modport slave (
    input  flush, in_valid, Shift_in, Shift_val, Mode, out_ready,
    output in_ready, out_valid, Shift_out, Shift_zero
  );
`endif

endinterface

// File: rtl/shift_stage.sv
// Combinational barrel section covering shamt bits [BASE +: NBITS].
// Carry tracking is built only when SHIFT_COUT_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NBITS = 2,
  parameter int unsigned BASE  = 0
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [NBITS-1:0]  shamt_i,
`ifdef SHIFT_COUT_EN
  input  logic              cin_i,
  output logic              cout_o,
`endif
  output logic [WIDTH-1:0]  data_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  int unsigned k;

  // Each level shifts by a fixed power of two; the carry is the last bit to
  // leave at the highest active level, otherwise the incoming carry survives.
  always_comb begin
    data_o = data_i;
    k      = 0;
`ifdef SHIFT_COUT_EN
    cout_o = cin_i;
`endif
    for (int i = 0; i < int'(NBITS); i++) begin
      k = 32'd1 << (BASE + i);
      if (shamt_i[i]) begin
`ifdef SHIFT_COUT_EN
        case (mode_i)
          SHIFT_SLL, SHIFT_ROL:            cout_o = data_o[SHW'(WIDTH - k)];
          SHIFT_SRA, SHIFT_SRL, SHIFT_ROR: cout_o = data_o[SHW'(k - 1)];
          default:                         cout_o = 1'b0;
        endcase
`endif
        case (mode_i)
          SHIFT_SLL: data_o = data_o << k;
          SHIFT_SRL: data_o = data_o >> k;
          SHIFT_SRA: data_o = $signed(data_o) >>> k;
          SHIFT_ROL: data_o = (data_o << k) | (data_o >> (WIDTH - k));
          SHIFT_ROR: data_o = (data_o >> k) | (data_o << (WIDTH - k));
          default:   data_o = data_o;
        endcase
      end
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter with valid/ready flow control and flush.
// Define SHIFT_COUT_EN to add the pipelined Shift_cout flag.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  shifter_pipe_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned S1  = (SHW + 1) / 2;
  localparam int unsigned S2  = SHW - S1;

  logic              v1_q, v2_q;
  logic [WIDTH-1:0]  data1_q, data2_q;
  logic [MODE_W-1:0] mode1_q;
  logic [S2-1:0]     shamt1_q;
  logic              zero2_q;
  logic [WIDTH-1:0]  s1_data, s2_data;
  logic              ld1, ld2, accept;

  assign ld2          = !v2_q || bus.out_ready;
  assign ld1          = !v1_q || ld2;
  assign bus.in_ready = ld1 && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef SHIFT_COUT_EN
  logic cout1_q, cout2_q;
  logic s1_cout, s2_cout;
`endif

  shift_stage #(
    .WIDTH (WIDTH),
    .NBITS (S1),
    .BASE  (0)
  ) u_stage1 (
    .mode_i  (bus.Mode),
    .data_i  (bus.Shift_in),
    .shamt_i (bus.Shift_val[S1-1:0]),
`ifdef SHIFT_COUT_EN
    .cin_i   (1'b0),
    .cout_o  (s1_cout),
`endif
    .data_o  (s1_data)
  );

  shift_stage #(
    .WIDTH (WIDTH),
    .NBITS (S2),
    .BASE  (S1)
  ) u_stage2 (
    .mode_i  (mode1_q),
    .data_i  (data1_q),
    .shamt_i (shamt1_q),
`ifdef SHIFT_COUT_EN
    .cin_i   (cout1_q),
    .cout_o  (s2_cout),
`endif
    .data_o  (s2_data)
  );

  // Flush wins over any accept/advance; data registers only move with a valid
  // token so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      data1_q  <= '0;
      mode1_q  <= '0;
      shamt1_q <= '0;
      data2_q  <= '0;
      zero2_q  <= 1'b0;
    end else if (bus.flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (ld1) begin
        v1_q <= bus.in_valid;
      end
      if (accept) begin
        data1_q  <= s1_data;
        mode1_q  <= bus.Mode;
        shamt1_q <= bus.Shift_val[SHW-1:S1];
      end
      if (ld2) begin
        v2_q <= v1_q;
      end
      if (ld2 && v1_q) begin
        data2_q <= s2_data;
        zero2_q <= (s2_data == '0);
      end
    end
  end

`ifdef SHIFT_COUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout1_q <= 1'b0;
      cout2_q <= 1'b0;
    end else if (!bus.flush) begin
      if (accept) begin
        cout1_q <= s1_cout;
      end
      if (ld2 && v1_q) begin
        cout2_q <= s2_cout;
      end
    end
  end

  assign bus.Shift_cout = cout2_q;
`endif

  assign bus.out_valid  = v2_q;
  assign bus.Shift_out  = data2_q;
  assign bus.Shift_zero = zero2_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed self-checking bench for shifter_pipe at WIDTH=16 and WIDTH=32.
module tb_shifter_pipe;
  import shifter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shifter_pipe_if #(.WIDTH(16)) b16 ();
  shifter_pipe_if #(.WIDTH(32)) b32 ();

  shifter_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  shifter_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_out(input bit wide);
    return wide ? b32.Shift_out : {16'h0, b16.Shift_out};
  endfunction

  function automatic logic get_vld(input bit wide);
    return wide ? b32.out_valid : b16.out_valid;
  endfunction

  function automatic logic get_rdy(input bit wide);
    return wide ? b32.in_ready : b16.in_ready;
  endfunction

  function automatic logic get_zero(input bit wide);
    return wide ? b32.Shift_zero : b16.Shift_zero;
  endfunction

`ifdef SHIFT_COUT_EN
  function automatic logic get_cout(input bit wide);
    return wide ? b32.Shift_cout : b16.Shift_cout;
  endfunction
`endif

  task automatic drive(input bit wide, input logic v, input logic [2:0] m,
                       input logic [31:0] d, input logic [4:0] s);
    if (wide) begin
      b32.in_valid = v; b32.Mode = m; b32.Shift_in = d; b32.Shift_val = s;
    end else begin
      b16.in_valid = v; b16.Mode = m; b16.Shift_in = d[15:0]; b16.Shift_val = s[3:0];
    end
  endtask

  // One isolated operation: accept, no result after one edge, result after two.
  task automatic run_op(input bit wide, input string tag, input logic [2:0] m,
                        input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp, input logic ez, input logic ec);
    @(negedge clk);
    drive(wide, 1'b1, m, d, s);
    #1 check_eq({tag, " rdy"}, get_rdy(wide), 1);
    @(negedge clk);
    drive(wide, 1'b0, 3'b000, 32'h0, 5'd0);
    #1 check_eq({tag, " lat"}, get_vld(wide), 0);
    @(negedge clk);
    #1 check_eq({tag, " vld"}, get_vld(wide), 1);
    check_eq({tag, " out"}, get_out(wide), exp);
    check_eq({tag, " zero"}, get_zero(wide), ez);
`ifdef SHIFT_COUT_EN
    check_eq({tag, " cout"}, get_cout(wide), ec);
`else
    if (ec === 1'bx) $display("note: %s carry expectation unknown", tag);
`endif
  endtask

  logic [9:0]  ival_t, ordy_t, irdy_t, ovld_t;
  int          op_sel [10];
  int          res_sel [10];
  logic [2:0]  bp_mode [4];
  logic [15:0] bp_in [4];
  logic [3:0]  bp_val [4];
  logic [15:0] bp_exp [4];

  initial begin
    b16.flush = 0; b16.in_valid = 0; b16.Shift_in = 0; b16.Shift_val = 0;
    b16.Mode = 0; b16.out_ready = 1;
    b32.flush = 0; b32.in_valid = 0; b32.Shift_in = 0; b32.Shift_val = 0;
    b32.Mode = 0; b32.out_ready = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst vld16", b16.out_valid, 0);
    check_eq("rst out16", b16.Shift_out, 0);
    check_eq("rst zero16", b16.Shift_zero, 0);
    check_eq("rst vld32", b32.out_valid, 0);
    check_eq("rst out32", b32.Shift_out, 0);
`ifdef SHIFT_COUT_EN
    check_eq("rst cout16", b16.Shift_cout, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    #1 check_eq("rst rdy16", b16.in_ready, 1);
    check_eq("rst rdy32", b32.in_ready, 1);

    run_op(0, "sra", SHIFT_SRA, 32'h8421, 5'd5, 32'hFC21, 0, 0);
    run_op(0, "rol", SHIFT_ROL, 32'h8001, 5'd1, 32'h0003, 0, 1);
    run_op(0, "ror", SHIFT_ROR, 32'h1234, 5'd4, 32'h4123, 0, 0);
    run_op(0, "srl15", SHIFT_SRL, 32'h8000, 5'd15, 32'h0001, 0, 0);
    run_op(0, "sll", SHIFT_SLL, 32'h8000, 5'd1, 32'h0000, 1, 1);
    run_op(0, "pass7", 3'b111, 32'hBEEF, 5'd7, 32'hBEEF, 0, 0);
    run_op(0, "pass5", 3'b101, 32'h0000, 5'd3, 32'h0000, 1, 0);
    run_op(0, "sll0", SHIFT_SLL, 32'h00FF, 5'd0, 32'h00FF, 0, 0);
    run_op(0, "rol15", SHIFT_ROL, 32'hBEEF, 5'd15, 32'hDF77, 0, 1);
    run_op(0, "srl8", SHIFT_SRL, 32'hFFFF, 5'd8, 32'h00FF, 0, 1);

    // Backpressure: four ops, consumer stalls cycles 2-4.
    bp_mode[0] = SHIFT_SLL; bp_in[0] = 16'h0001; bp_val[0] = 4'd1; bp_exp[0] = 16'h0002;
    bp_mode[1] = SHIFT_ROR; bp_in[1] = 16'h0001; bp_val[1] = 4'd1; bp_exp[1] = 16'h8000;
    bp_mode[2] = SHIFT_SRA; bp_in[2] = 16'h8000; bp_val[2] = 4'd2; bp_exp[2] = 16'hE000;
    bp_mode[3] = SHIFT_SRL; bp_in[3] = 16'h8000; bp_val[3] = 4'd3; bp_exp[3] = 16'h1000;
    ival_t = 10'b0001111111;
    ordy_t = 10'b1111100011;
    irdy_t = 10'b1111100011;
    ovld_t = 10'b0111111100;
    op_sel  = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0};
    res_sel = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b16.out_ready = ordy_t[c];
      drive(0, ival_t[c], bp_mode[op_sel[c]], {16'h0, bp_in[op_sel[c]]},
            {1'b0, bp_val[op_sel[c]]});
      #1;
      check_eq($sformatf("bp rdy c%0d", c), b16.in_ready, irdy_t[c]);
      check_eq($sformatf("bp vld c%0d", c), b16.out_valid, ovld_t[c]);
      if (ovld_t[c]) begin
        check_eq($sformatf("bp out c%0d", c), b16.Shift_out, bp_exp[res_sel[c]]);
      end
    end

    // Flush a full pipeline with a coincident input.
    @(negedge clk);
    b16.out_ready = 1'b0;
    drive(0, 1'b1, SHIFT_SLL, 32'h0001, 5'd1);
    @(negedge clk);
    drive(0, 1'b1, SHIFT_SRL, 32'h8000, 5'd1);
    @(negedge clk);
    b16.flush = 1'b1;
    drive(0, 1'b1, SHIFT_ROL, 32'h00F0, 5'd4);
    #1 check_eq("fl rdy", b16.in_ready, 0);
    check_eq("fl full", b16.out_valid, 1);
    @(negedge clk);
    b16.flush = 1'b0;
    b16.out_ready = 1'b1;
    drive(0, 1'b0, 3'b000, 32'h0, 5'd0);
    #1 check_eq("fl vld0", b16.out_valid, 0);
    @(negedge clk);
    #1 check_eq("fl vld1", b16.out_valid, 0);
    run_op(0, "fl next", SHIFT_SLL, 32'h00F0, 5'd4, 32'h0F00, 0, 0);

    run_op(1, "sra31", SHIFT_SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 0, 0);
    run_op(1, "rol16", SHIFT_ROL, 32'h80000001, 5'd16, 32'h00018000, 0, 0);
    run_op(1, "srl17", SHIFT_SRL, 32'hFFFFFFFF, 5'd17, 32'h00007FFF, 0, 1);

    // Asynchronous reset with results in flight.
    @(negedge clk);
    drive(1, 1'b1, SHIFT_SLL, 32'h1, 5'd1);
    drive(0, 1'b1, SHIFT_SLL, 32'h1, 5'd2);
    @(negedge clk);
    drive(1, 1'b1, SHIFT_SLL, 32'h1, 5'd3);
    @(negedge clk);
    #1 check_eq("mr vld", b32.out_valid, 1);
    check_eq("mr out", b32.Shift_out, 32'h2);
    #2 rst_n = 1'b0;
    #1 check_eq("mr rst vld32", b32.out_valid, 0);
    check_eq("mr rst out32", b32.Shift_out, 0);
    check_eq("mr rst zero32", b32.Shift_zero, 0);
    check_eq("mr rst vld16", b16.out_valid, 0);
    check_eq("mr rst out16", b16.Shift_out, 0);
`ifdef SHIFT_COUT_EN
    check_eq("mr rst cout32", b32.Shift_cout, 0);
`endif
    drive(1, 1'b0, 3'b000, 32'h0, 5'd0);
    drive(0, 1'b0, 3'b000, 32'h0, 5'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(1, "post rst", SHIFT_SLL, 32'h00000001, 5'd31, 32'h80000000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
